// File: rtl/axis_register.sv
// Single-stage AXI4-Stream register: skid buffer, simple buffer or bypass, chosen by MODE.
// Disabled sidebands are forced to zero at the input so that their storage folds away.
module axis_register #(
    parameter int MODE           = 0,
    parameter int TREADY_RST_VAL = 0,
    parameter int ENABLE_TKEEP   = 1,
    parameter int ENABLE_TLAST   = 1,
    parameter int ENABLE_TID     = 0,
    parameter int ENABLE_TDEST   = 0,
    parameter int ENABLE_TUSER   = 1,
    parameter int TDATA_WIDTH    = 512,
    parameter int TID_WIDTH      = 8,
    parameter int TDEST_WIDTH    = 8,
    parameter int TUSER_WIDTH    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     s_tready,
    input  logic                     s_tvalid,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic                     s_tlast,
    input  logic [TID_WIDTH-1:0]     s_tid,
    input  logic [TDEST_WIDTH-1:0]   s_tdest,
    input  logic [TUSER_WIDTH-1:0]   s_tuser,
    input  logic                     m_tready,
    output logic                     m_tvalid,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [TID_WIDTH-1:0]     m_tid,
    output logic [TDEST_WIDTH-1:0]   m_tdest,
    output logic [TUSER_WIDTH-1:0]   m_tuser
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int PW = TDATA_WIDTH + KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    logic [KW-1:0]          keep_in;
    logic                   last_in;
    logic [TID_WIDTH-1:0]   id_in;
    logic [TDEST_WIDTH-1:0] dest_in;
    logic [TUSER_WIDTH-1:0] user_in;
    logic [PW-1:0]          s_payload;
    logic [PW-1:0]          m_payload;

    assign keep_in   = (ENABLE_TKEEP != 0) ? s_tkeep : '0;
    assign last_in   = (ENABLE_TLAST != 0) ? s_tlast : 1'b0;
    assign id_in     = (ENABLE_TID   != 0) ? s_tid   : '0;
    assign dest_in   = (ENABLE_TDEST != 0) ? s_tdest : '0;
    assign user_in   = (ENABLE_TUSER != 0) ? s_tuser : '0;
    assign s_payload = {s_tdata, keep_in, last_in, id_in, dest_in, user_in};
    assign {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = m_payload;

    if (MODE == 0) begin : g_skid
        typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

        state_t        state_q, state_d;
        logic          s_tready_q, s_tready_d;
        logic          m_tvalid_q, m_tvalid_d;
        logic [PW-1:0] out_q, out_d;
        logic [PW-1:0] skid_q, skid_d;
        logic          accept;

        assign accept = s_tvalid && s_tready_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= EMPTY;
                s_tready_q <= (TREADY_RST_VAL != 0);
                m_tvalid_q <= 1'b0;
                out_q      <= '0;
                skid_q     <= '0;
            end else begin
                state_q    <= state_d;
                s_tready_q <= s_tready_d;
                m_tvalid_q <= m_tvalid_d;
                out_q      <= out_d;
                skid_q     <= skid_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !m_tready)      state_d = TWO;
                    else if (!accept && m_tready) state_d = EMPTY;
                end
                TWO:     if (m_tready) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end

        // Ready and valid are decoded from the next state so both leave as flop outputs.
        always_comb begin
            out_d  = out_q;
            skid_d = skid_q;
            case (state_q)
                EMPTY: if (accept) out_d = s_payload;
                ONE: begin
                    if (accept && m_tready)       out_d  = s_payload;
                    else if (accept && !m_tready) skid_d = s_payload;
                end
                TWO:     if (m_tready) out_d = skid_q;
                default: ;
            endcase
            m_tvalid_d = (state_d != EMPTY);
            s_tready_d = (state_d != TWO);
        end

        assign s_tready  = s_tready_q;
        assign m_tvalid  = m_tvalid_q;
        assign m_payload = out_q;
    end else if (MODE == 1) begin : g_simple
        logic          s_tready_q, s_tready_d;
        logic          m_tvalid_q, m_tvalid_d;
        logic [PW-1:0] out_q, out_d;
        logic          accept;

        assign accept = s_tvalid && s_tready_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_tready_q <= (TREADY_RST_VAL != 0);
                m_tvalid_q <= 1'b0;
                out_q      <= '0;
            end else begin
                s_tready_q <= s_tready_d;
                m_tvalid_q <= m_tvalid_d;
                out_q      <= out_d;
            end
        end

        always_comb begin
            m_tvalid_d = m_tvalid_q;
            out_d      = out_q;
            if (accept) begin
                m_tvalid_d = 1'b1;
                out_d      = s_payload;
            end else if (m_tready) begin
                m_tvalid_d = 1'b0;
            end
            s_tready_d = !m_tvalid_d;
        end

        assign s_tready  = s_tready_q;
        assign m_tvalid  = m_tvalid_q;
        assign m_payload = out_q;
    end else begin : g_bypass
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst;
        assign s_tready       = m_tready;
        assign m_tvalid       = s_tvalid;
        assign m_payload      = s_payload;
    end

endmodule

// File: tb/tb_axis_register.sv
// Bench for axis_register: four instances (skid, skid with ready-in-reset, simple, bypass)
// driven one at a time; a queue scoreboard checks every beat leaving the selected instance.
module tb_axis_register;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 1;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           s_tready[N], s_tvalid[N], s_tlast[N];
    logic [DW-1:0]  s_tdata[N];
    logic [KW-1:0]  s_tkeep[N];
    logic [IW-1:0]  s_tid[N];
    logic [DSW-1:0] s_tdest[N];
    logic [UW-1:0]  s_tuser[N];
    logic           m_tready[N], m_tvalid[N], m_tlast[N];
    logic [DW-1:0]  m_tdata[N];
    logic [KW-1:0]  m_tkeep[N];
    logic [IW-1:0]  m_tid[N];
    logic [DSW-1:0] m_tdest[N];
    logic [UW-1:0]  m_tuser[N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        axis_register #(
            .MODE          ((g == 3) ? 2 : (g == 2) ? 1 : 0),
            .TREADY_RST_VAL((g == 1) ? 1 : 0),
            .ENABLE_TKEEP  ((g == 3) ? 0 : 1),
            .ENABLE_TLAST  (1),
            .ENABLE_TID    ((g == 3) ? 0 : 1),
            .ENABLE_TDEST  (1),
            .ENABLE_TUSER  (1),
            .TDATA_WIDTH   (DW),
            .TID_WIDTH     (IW),
            .TDEST_WIDTH   (DSW),
            .TUSER_WIDTH   (UW)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .s_tready(s_tready[g]),
            .s_tvalid(s_tvalid[g]),
            .s_tdata (s_tdata[g]),
            .s_tkeep (s_tkeep[g]),
            .s_tlast (s_tlast[g]),
            .s_tid   (s_tid[g]),
            .s_tdest (s_tdest[g]),
            .s_tuser (s_tuser[g]),
            .m_tready(m_tready[g]),
            .m_tvalid(m_tvalid[g]),
            .m_tdata (m_tdata[g]),
            .m_tkeep (m_tkeep[g]),
            .m_tlast (m_tlast[g]),
            .m_tid   (m_tid[g]),
            .m_tdest (m_tdest[g]),
            .m_tuser (m_tuser[g])
        );
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    sel    = 0;
    beat_t q[$];
    int    acc_cyc[$];
    int    pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bypass instance has tkeep and tid disabled: those fields must come out as zero.
    function automatic beat_t expect_of(input beat_t b, input int g);
        beat_t e;
        e = b;
        if (g == 3) begin
            e.keep = '0;
            e.id   = '0;
        end
        return e;
    endfunction

    function automatic beat_t get_m(input int g);
        beat_t b;
        b.data = m_tdata[g];
        b.keep = m_tkeep[g];
        b.last = m_tlast[g];
        b.id   = m_tid[g];
        b.dest = m_tdest[g];
        b.user = m_tuser[g];
        return b;
    endfunction

    task automatic drive(input int g, input beat_t b);
        s_tdata[g] = b.data;
        s_tkeep[g] = b.keep;
        s_tlast[g] = b.last;
        s_tid[g]   = b.id;
        s_tdest[g] = b.dest;
        s_tuser[g] = b.user;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.data = $urandom;
        b.keep = KW'($urandom);
        b.last = 1'($urandom);
        b.id   = IW'($urandom);
        b.dest = DSW'($urandom);
        b.user = UW'($urandom);
        return b;
    endfunction

    // Monitor: sampled mid-cycle, after the driver's negedge push and before the next edge.
    initial begin
        beat_t prev, cur, e;
        logic  stall_prev;
        stall_prev = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                cur = get_m(sel);
                if (stall_prev) begin
                    checks++;
                    if (!m_tvalid[sel] || cur !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b beat=%h expected valid=1 beat=%h",
                                 m_tvalid[sel], cur, prev);
                    end
                end
                if (m_tvalid[sel] && m_tready[sel]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_unexpected: got beat %h expected none", cur);
                    end else begin
                        e = q.pop_front();
                        pop_cyc.push_back(cyc);
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL scoreboard_beat: got %h expected %h", cur, e);
                        end
                    end
                end
                stall_prev = m_tvalid[sel] && !m_tready[sel];
                prev       = cur;
            end
        end
    end

    task automatic send(input beat_t b);
        int unsigned n;
        n = 0;
        drive(sel, b);
        s_tvalid[sel] = 1'b1;
        @(negedge clk);
        while (!s_tready[sel] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (s_tready[sel]) begin
            q.push_back(expect_of(b, sel));
            acc_cyc.push_back(cyc);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_tready=0 expected 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        s_tvalid[sel] = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(q.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        acc_cyc.delete();
        pop_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int g);
        bit done;
        sel  = g;
        done = 1'b0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    beat_t b;
                    b = rand_beat();
                    repeat ($urandom_range(0, 2)) begin
                        drive(g, rand_beat());
                        @(posedge clk);
                        #1;
                    end
                    send(b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready[g] = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                m_tready[g] = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b;
        for (int g = 0; g < N; g++) begin
            s_tvalid[g] = 1'b0;
            m_tready[g] = (g == 3);
            drive(g, '0);
        end

        // Reset values and first edge after release
        #12;
        check("rst_s_tready_skid0", 64'(s_tready[0]), 0);
        check("rst_m_tvalid_skid0", 64'(m_tvalid[0]), 0);
        check("rst_m_tdata_skid0", 64'(m_tdata[0]), 0);
        check("rst_s_tready_skid1", 64'(s_tready[1]), 1);
        check("rst_m_tvalid_skid1", 64'(m_tvalid[1]), 0);
        check("rst_s_tready_simple", 64'(s_tready[2]), 0);
        check("rst_bypass_ready", 64'(s_tready[3]), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_before_edge", 64'(s_tready[0]), 0);
        @(posedge clk);
        #1;
        check("rel_s_tready_skid0", 64'(s_tready[0]), 1);
        check("rel_s_tready_skid1", 64'(s_tready[1]), 1);
        check("rel_s_tready_simple", 64'(s_tready[2]), 1);
        check("rel_m_tvalid_skid0", 64'(m_tvalid[0]), 0);

        // Streaming through the skid buffer
        sel = 0;
        do_reset();
        m_tready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b.data = DW'(i);
            b.keep = '1;
            b.last = (i == 7);
            b.id   = IW'(i);
            b.dest = DSW'(8'hF0 + i);
            b.user = UW'(i % 2);
            send(b);
        end
        drain();
        if (pop_cyc.size() < 8 || acc_cyc.size() < 8) begin
            check("stream_count", 64'(pop_cyc.size()), 8);
        end else begin
            check("stream_latency", 64'(pop_cyc[0] - acc_cyc[0]), 1);
            for (int i = 1; i < 8; i++) check("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 1);
        end

        // Backpressure into the skid register
        do_reset();
        m_tready[0] = 1'b0;
        b = '0;
        b.data = 32'hA;
        send(b);
        b.data = 32'hB;
        send(b);
        check("bp_s_tready_low", 64'(s_tready[0]), 0);
        check("bp_m_tvalid", 64'(m_tvalid[0]), 1);
        check("bp_m_tdata_A", 64'(m_tdata[0]), 32'hA);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_A", 64'(m_tdata[0]), 32'hA);
        check("bp_hold_ready", 64'(s_tready[0]), 0);
        m_tready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_m_tdata_B", 64'(m_tdata[0]), 32'hB);
        check("bp_s_tready_back", 64'(s_tready[0]), 1);
        @(posedge clk);
        #1;
        check("bp_empty", 64'(m_tvalid[0]), 0);
        drain();

        // Random traffic, skid then simple
        random_run(0);
        random_run(2);

        // Simple buffer half rate
        sel = 2;
        do_reset();
        m_tready[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = rand_beat();
            send(b);
        end
        drain();
        if (acc_cyc.size() < 6 || pop_cyc.size() < 6) begin
            check("half_count", 64'(acc_cyc.size()), 6);
        end else begin
            check("half_latency", 64'(pop_cyc[0] - acc_cyc[0]), 1);
            for (int i = 1; i < 6; i++) check("half_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 2);
        end

        // Bypass: combinational pass-through, disabled fields tied low
        sel = 3;
        do_reset();
        @(posedge clk);
        #1;
        m_tready[3] = 1'b0;
        s_tvalid[3] = 1'b1;
        s_tdata[3]  = 32'h1234_5678;
        s_tid[3]    = 8'h55;
        s_tkeep[3]  = 4'hF;
        s_tdest[3]  = 8'h3C;
        #1;
        check("byp_tdata", 64'(m_tdata[3]), 32'h1234_5678);
        check("byp_tvalid", 64'(m_tvalid[3]), 1);
        check("byp_tdest", 64'(m_tdest[3]), 8'h3C);
        check("byp_tid_off", 64'(m_tid[3]), 0);
        check("byp_tkeep_off", 64'(m_tkeep[3]), 0);
        check("byp_ready_lo", 64'(s_tready[3]), 0);
        m_tready[3] = 1'b1;
        s_tdata[3]  = 32'hCAFE_0001;
        #1;
        check("byp_ready_hi", 64'(s_tready[3]), 1);
        check("byp_tdata2", 64'(m_tdata[3]), 32'hCAFE_0001);
        s_tvalid[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = rand_beat();
            send(b);
        end
        drain();
        if (acc_cyc.size() >= 1 && pop_cyc.size() >= 1)
            check("byp_latency", 64'(pop_cyc[0] - acc_cyc[0]), 0);
        else
            check("byp_count", 64'(pop_cyc.size()), 4);

        // Reset while the skid holds two beats
        sel = 0;
        do_reset();
        m_tready[0] = 1'b0;
        b = '0;
        b.data = 32'hC;
        send(b);
        b.data = 32'hD;
        send(b);
        check("mid_two_ready", 64'(s_tready[0]), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", 64'(m_tvalid[0]), 0);
        check("mid_rst_s_tready", 64'(s_tready[0]), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        m_tready[0] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mid_no_stale", 64'(m_tvalid[0]), 0);
        end
        check("mid_ready_back", 64'(s_tready[0]), 1);
        b.data = 32'hE;
        send(b);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_register.md
Name: axis_register

Overview:
- Generic single-stage AXI4-Stream pipeline register, one clock domain.
- Cut timing between an upstream source and a downstream sink.
- Instantiated in chains by interface-specific wrappers, e.g. PCIe RX/TX pipelines.
- Three build-time modes: skid buffer (full throughput, all outputs registered), simple buffer (one register, half throughput), bypass (wires).

Parameters:
- MODE, 0: 0 = skid buffer, 1 = simple buffer, 2 = bypass.
- TREADY_RST_VAL, 0: value of s_tready while rst is asserted (0 = deasserted, 1 = asserted). Modes 0/1 only.
- ENABLE_TKEEP, 1: 1 = carry tkeep.
- ENABLE_TLAST, 1: 1 = carry tlast.
- ENABLE_TID, 0: 1 = carry tid.
- ENABLE_TDEST, 0: 1 = carry tdest.
- ENABLE_TUSER, 1: 1 = carry tuser.
- TDATA_WIDTH, 512: tdata width, a multiple of 8.
- TID_WIDTH, 8: tid width.
- TDEST_WIDTH, 8: tdest width.
- TUSER_WIDTH, 1: tuser width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tready  out  1  slave ready.
- s_tvalid  in  1  slave valid.
- s_tdata  in  TDATA_WIDTH  slave data.
- s_tkeep  in  TDATA_WIDTH/8  slave byte keep.
- s_tlast  in  1  slave end of packet.
- s_tid  in  TID_WIDTH  slave stream id.
- s_tdest  in  TDEST_WIDTH  slave destination.
- s_tuser  in  TUSER_WIDTH  slave sideband.
- m_tready  in  1  master ready.
- m_tvalid  out  1  master valid.
- m_tdata  out  TDATA_WIDTH  master data.
- m_tkeep  out  TDATA_WIDTH/8  master byte keep.
- m_tlast  out  1  master end of packet.
- m_tid  out  TID_WIDTH  master stream id.
- m_tdest  out  TDEST_WIDTH  master destination.
- m_tuser  out  TUSER_WIDTH  master sideband.

Behaviour:
- Handshake rules:
  - A beat transfers on a rising edge where tvalid and tready are both 1.
  - Payload = {tdata, tkeep, tlast, tid, tdest, tuser}. Beats are never dropped, duplicated or reordered.
  - m_tvalid and the m_ payload are held stable while m_tvalid = 1 and m_tready = 0.
- Disabled sidebands (ENABLE_x = 0): the s_ input is ignored, the m_ output is tied to 0, and no flops are created.
- Reset (rst = 1, asynchronous):
  - m_tvalid = 0 and the skid valid = 0.
  - Payload registers are cleared to 0.
  - s_tready = TREADY_RST_VAL.
  - On the first edge after rst falls, s_tready = 1 in modes 0/1.
  - Reset asserted mid-transfer discards all held beats.
- MODE 0, skid buffer:
  - States: EMPTY (out invalid), ONE (out valid, skid empty), TWO (out valid, skid full).
  - s_tready is a flop output equal to 1 unless in TWO.
  - EMPTY: an accepted beat goes to the output register, giving ONE. Latency is 1 cycle.
  - ONE: with accept and m_tready, the output reg loads the new beat and the state stays ONE. With accept and no m_tready, the beat goes to skid, giving TWO. With no accept and m_tready, the state goes to EMPTY.
  - TWO: on m_tready, the skid beat moves to the output reg, giving ONE, and s_tready rises the next cycle.
  - Sustained throughput is 1 beat/cycle. No combinational path from m_tready to s_tready.
- MODE 1, simple buffer:
  - Single output register; s_tready = NOT m_tvalid (register-derived).
  - A beat is accepted only when the register is empty. It is removed on m_tready.
  - Latency is 1 cycle. Maximum throughput is 1 beat per 2 cycles.
- MODE 2, bypass:
  - m_* = s_* and s_tready = m_tready, combinationally.
  - Zero latency, no flops. rst and TREADY_RST_VAL have no effect.
- Boundary conditions:
  - The s_tvalid and s_tready relationship never causes loss: an input presented while s_tready = 0 is simply not accepted.
  - An X or changing payload while tvalid = 0 is ignored.

Test Plan:
- Reset behaviour: MODE 0, TREADY_RST_VAL = 0, rst = 1 → s_tready = 0, m_tvalid = 0. Release rst → s_tready = 1 the next cycle. Repeat with TREADY_RST_VAL = 1 → s_tready = 1 during reset.
- Streaming: MODE 0, m_tready = 1, stream 8 beats tdata = 0..7, tlast on beat 7 → m_tvalid one cycle after the first beat, beats 0..7 in order on consecutive cycles, tlast only with 7, tuser passed intact.
- Backpressure: MODE 0, m_tready = 0 while sending beats 0xA, 0xB → m_tdata = 0xA held, s_tready = 0 after 0xB. Raise m_tready → 0xA then 0xB output, s_tready returns to 1.
- Random traffic: MODE 0 and MODE 1, random s_tvalid and m_tready over 1000 beats with ENABLE_TID = ENABLE_TDEST = 1 → scoreboard exact in-order match, and stable-while-stalled assertion holds.
- Half-rate throughput: MODE 1, s_tvalid and m_tready constantly 1 → accepted beats alternate cycles (50% rate), s_tready toggles 1/0.
- Bypass and mid-traffic reset: MODE 2 → m_tdata equals s_tdata in the same cycle and s_tready follows m_tready. MODE 0 with rst asserted while in TWO → m_tvalid = 0 immediately, and no stale beat appears after release.
